// File: rtl/pipo_load_arbiter_if.sv
// Requester/consumer bundle around the shared PIPO holding register.
// slave = arbiter side, master = requesters plus output consumer.
interface pipo_load_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
) ();
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] din;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      dout;
  logic                  dout_valid;
  logic [OW-1:0]         owner;
  logic                  busy;

  modport slave (
    input  req, din,
    output gnt, dout, dout_valid, owner, busy
  );

  modport master (
    output req, din,
    input  gnt, dout, dout_valid, owner, busy
  );
endinterface

// File: rtl/pipo_load_arbiter.sv
// Round-robin arbiter that loads one winner's word into a shared register, 1 cycle req->dout.
// No backpressure: after each capture req is ignored for HOLD cycles (busy), giving 1 capture per HOLD+1.
module pipo_load_arbiter #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4,
  parameter int HOLD  = 2
) (
  input  logic               clk,
  input  logic               rst,
  pipo_load_arbiter_if.slave bus
);
  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(HOLD + 1);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t           r_state, w_state_nxt;
  logic [PW-1:0]    r_ptr, w_ptr_nxt;
  logic [PW-1:0]    r_owner, w_owner_nxt;
  logic [PW-1:0]    w_winner;
  logic [PW:0]      w_idx;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [NREQ-1:0]  r_gnt, w_gnt_nxt;
  logic [WIDTH-1:0] r_dout, w_dout_nxt;
  logic             r_dout_valid, w_dout_valid_nxt;
  logic             w_found;

  // First set request scanning from ptr upward, wrapping modulo NREQ.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_idx >= (PW+1)'(NREQ)) w_idx = w_idx - (PW+1)'(NREQ);
      if (!w_found && bus.req[w_idx[PW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[PW-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_ptr_nxt        = r_ptr;
    w_cnt_nxt        = r_cnt;
    w_gnt_nxt        = '0;
    w_dout_nxt       = r_dout;
    w_dout_valid_nxt = r_dout_valid;
    w_owner_nxt      = r_owner;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_dout_nxt          = bus.din[w_winner*WIDTH +: WIDTH];
          w_owner_nxt         = w_winner;
          w_gnt_nxt[w_winner] = 1'b1;
          w_dout_valid_nxt    = 1'b1;
          w_ptr_nxt           = (w_winner == PW'(NREQ-1)) ? '0 : w_winner + PW'(1);
          w_cnt_nxt           = CW'(HOLD);
          w_state_nxt         = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_cnt == CW'(1)) w_state_nxt = S_IDLE;
        else                 w_cnt_nxt   = r_cnt - CW'(1);
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_cnt        <= '0;
      r_gnt        <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_owner      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_cnt        <= w_cnt_nxt;
      r_gnt        <= w_gnt_nxt;
      r_dout       <= w_dout_nxt;
      r_dout_valid <= w_dout_valid_nxt;
      r_owner      <= w_owner_nxt;
    end
  end

  assign bus.gnt        = r_gnt;
  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
  assign bus.owner      = r_owner;
  assign bus.busy       = (r_state == S_HOLD);
endmodule

// File: tb/tb_pipo_load_arbiter.sv
// Directed bench for pipo_load_arbiter (WIDTH=4, NREQ=4, HOLD=2).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_pipo_load_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  pipo_load_arbiter_if #(.WIDTH(4), .NREQ(4)) bus ();

  pipo_load_arbiter #(.WIDTH(4), .NREQ(4), .HOLD(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst     = 1'b0;
    bus.req = 4'b1111;
    bus.din = 16'h8421;
    for (int c = 0; c < 2; c++) begin
      tick();
      if (bus.gnt !== 4'b0000) begin $display("FAIL reset_gnt cyc=%0d got=%b want=0000", c, bus.gnt); errors++; end
      checks++;
      if (bus.dout !== 4'h0) begin $display("FAIL reset_dout cyc=%0d got=%h want=0", c, bus.dout); errors++; end
      checks++;
      if (bus.dout_valid !== 1'b0) begin $display("FAIL reset_valid cyc=%0d got=%b want=0", c, bus.dout_valid); errors++; end
      checks++;
      if (bus.owner !== 2'd0) begin $display("FAIL reset_owner cyc=%0d got=%0d want=0", c, bus.owner); errors++; end
      checks++;
      if (bus.busy !== 1'b0) begin $display("FAIL reset_busy cyc=%0d got=%b want=0", c, bus.busy); errors++; end
      checks++;
    end
    bus.req = 4'b0000;
    rst     = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bus.req = 4'b0100;
    bus.din = 16'h0A00;
    tick();
    if (bus.dout !== 4'b1010) begin $display("FAIL single_dout got=%b want=1010", bus.dout); errors++; end
    checks++;
    if (bus.owner !== 2'd2) begin $display("FAIL single_owner got=%0d want=2", bus.owner); errors++; end
    checks++;
    if (bus.gnt !== 4'b0100) begin $display("FAIL single_gnt got=%b want=0100", bus.gnt); errors++; end
    checks++;
    if (bus.busy !== 1'b1 || bus.dout_valid !== 1'b1) begin
      $display("FAIL single_busy_valid got=%b%b want=11", bus.busy, bus.dout_valid); errors++;
    end
    checks++;
    bus.req = 4'b0000;
    tick();
    if (bus.gnt !== 4'b0000 || bus.busy !== 1'b1) begin
      $display("FAIL single_hold1 gnt=%b busy=%b want gnt=0000 busy=1", bus.gnt, bus.busy); errors++;
    end
    checks++;
    tick();
    if (bus.busy !== 1'b0) begin $display("FAIL single_hold_end busy=%b want=0", bus.busy); errors++; end
    checks++;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bus.gnt !== 4'b0000 || bus.dout !== 4'b1010) begin
        $display("FAIL single_idle cyc=%0d gnt=%b dout=%b want gnt=0000 dout=1010", c, bus.gnt, bus.dout); errors++;
      end
      checks++;
    end
  endtask

  task automatic test_all_requesting();
    logic [3:0] exp_g;
    logic [1:0] exp_o;
    rst = 1'b0;
    tick();
    rst     = 1'b1;
    bus.req = 4'b1111;
    bus.din = 16'h8421;
    for (int i = 0; i < 5; i++) begin
      exp_g = 4'b0001 << (i % 4);
      exp_o = 2'(i % 4);
      tick();
      if (bus.owner !== exp_o || bus.gnt !== exp_g || bus.dout !== exp_g) begin
        $display("FAIL all_capture n=%0d owner=%0d gnt=%b dout=%b want owner=%0d gnt=%b dout=%b",
                 i, bus.owner, bus.gnt, bus.dout, exp_o, exp_g, exp_g);
        errors++;
      end
      checks++;
      tick();
      if (bus.gnt !== 4'b0000 || bus.busy !== 1'b1) begin
        $display("FAIL all_gap1 n=%0d gnt=%b busy=%b want gnt=0000 busy=1", i, bus.gnt, bus.busy); errors++;
      end
      checks++;
      tick();
      if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
        $display("FAIL all_gap2 n=%0d gnt=%b busy=%b want gnt=0000 busy=0", i, bus.gnt, bus.busy); errors++;
      end
      checks++;
    end
  endtask

  task automatic test_wrap_priority();
    bus.req = 4'b1000;
    tick();
    if (bus.owner !== 2'd3 || bus.gnt !== 4'b1000) begin
      $display("FAIL wrap_first owner=%0d gnt=%b want owner=3 gnt=1000", bus.owner, bus.gnt); errors++;
    end
    checks++;
    bus.req = 4'b1001;
    tick();
    tick();
    tick();
    if (bus.owner !== 2'd0 || bus.gnt !== 4'b0001 || bus.dout !== 4'b0001) begin
      $display("FAIL wrap_to0 owner=%0d gnt=%b dout=%b want owner=0 gnt=0001 dout=0001", bus.owner, bus.gnt, bus.dout);
      errors++;
    end
    checks++;
    tick();
    tick();
    tick();
    if (bus.owner !== 2'd3 || bus.gnt !== 4'b1000 || bus.dout !== 4'b1000) begin
      $display("FAIL wrap_to3 owner=%0d gnt=%b dout=%b want owner=3 gnt=1000 dout=1000", bus.owner, bus.gnt, bus.dout);
      errors++;
    end
    checks++;
    bus.req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_hold();
    bus.req = 4'b0010;
    tick();
    if (bus.owner !== 2'd1 || bus.gnt !== 4'b0010) begin
      $display("FAIL midrst_capture owner=%0d gnt=%b want owner=1 gnt=0010", bus.owner, bus.gnt); errors++;
    end
    checks++;
    rst = 1'b0;
    tick();
    if (bus.gnt !== 4'b0000 || bus.dout !== 4'h0 || bus.dout_valid !== 1'b0 ||
        bus.owner !== 2'd0 || bus.busy !== 1'b0) begin
      $display("FAIL midrst_outputs gnt=%b dout=%h valid=%b owner=%0d busy=%b want all zero",
               bus.gnt, bus.dout, bus.dout_valid, bus.owner, bus.busy);
      errors++;
    end
    checks++;
    rst = 1'b1;
    tick();
    if (bus.owner !== 2'd1 || bus.gnt !== 4'b0010 || bus.dout !== 4'b0010 || bus.busy !== 1'b1) begin
      $display("FAIL midrst_release owner=%0d gnt=%b dout=%b busy=%b want owner=1 gnt=0010 dout=0010 busy=1",
               bus.owner, bus.gnt, bus.dout, bus.busy);
      errors++;
    end
    checks++;
    bus.req = 4'b0000;
    tick();
    if (bus.busy !== 1'b1) begin $display("FAIL midrst_busy2 busy=%b want=1", bus.busy); errors++; end
    checks++;
    tick();
    if (bus.busy !== 1'b0) begin $display("FAIL midrst_busy_end busy=%b want=0", bus.busy); errors++; end
    checks++;
  endtask

  task automatic test_requests_during_hold();
    bus.req = 4'b0100;
    tick();
    if (bus.owner !== 2'd2 || bus.dout !== 4'b0100) begin
      $display("FAIL holdreq_first owner=%0d dout=%b want owner=2 dout=0100", bus.owner, bus.dout); errors++;
    end
    checks++;
    bus.req = 4'b0001;
    for (int c = 0; c < 2; c++) begin
      tick();
      if (bus.gnt !== 4'b0000 || bus.dout !== 4'b0100) begin
        $display("FAIL holdreq_blocked cyc=%0d gnt=%b dout=%b want gnt=0000 dout=0100", c, bus.gnt, bus.dout);
        errors++;
      end
      checks++;
    end
    tick();
    if (bus.owner !== 2'd0 || bus.gnt !== 4'b0001 || bus.dout !== 4'b0001) begin
      $display("FAIL holdreq_capture owner=%0d gnt=%b dout=%b want owner=0 gnt=0001 dout=0001",
               bus.owner, bus.gnt, bus.dout);
      errors++;
    end
    checks++;
    bus.req = 4'b0000;
    tick();
  endtask

  initial begin
    rst     = 1'b0;
    bus.req = '0;
    bus.din = '0;
    test_reset();
    test_single();
    test_all_requesting();
    test_wrap_priority();
    test_reset_mid_hold();
    test_requests_during_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipo_load_arbiter.md
# pipo_load_arbiter

Round-robin arbiter and sequencer that shares one parallel-in/parallel-out holding register between NREQ requesters. Each requester presents a data word and a request. The arbiter picks one winner, captures its word into the shared register, and returns a one-cycle grant. It then enforces a programmable hold window before the next capture. It sits between multiple producers and any consumer that reads the shared PIPO output.

## Interface
- WIDTH, 4, data width of each requester word and of the shared register
- NREQ, 4, number of requesters (2..16)
- HOLD, 2, cycles the register is held after a capture before the next grant (≥1)

- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-low (asserted when 0, sampled on clk rising edge)
- req  input  NREQ  request per requester, level; bit i belongs to requester i
- din  input  NREQ*WIDTH  requester words; requester i occupies bits [i*WIDTH +: WIDTH]
- gnt  output  NREQ  one-hot grant pulse, registered
- dout  output  WIDTH  shared register contents
- dout_valid  output  1  register holds a captured word since reset
- owner  output  clog2(NREQ)  index of requester whose word is in dout
- busy  output  1  hold window active; no capture possible

## Operation
- FSM states are IDLE and HOLD. There is also a round-robin pointer `ptr` (clog2(NREQ) bits) and a hold counter `cnt` (clog2(HOLD+1) bits).
- In IDLE with any req bit set, the winner is the first set req bit found when searching ptr, ptr+1, … modulo NREQ. On that edge:
  - dout ← din slice of the winner
  - owner ← winner
  - gnt ← onehot(winner)
  - dout_valid ← 1
  - ptr ← (winner+1) mod NREQ
  - cnt ← HOLD
  - state ← HOLD
- In IDLE with no req set, nothing changes and gnt ← 0.
- In HOLD, gnt ← 0 and req is ignored. If cnt==1, state ← IDLE; otherwise cnt ← cnt−1.
- busy = (state==HOLD), decoded from the registered state.
- dout, owner and dout_valid change only on a capture edge or on reset.
- A requester must deassert req, or change din, after seeing its gnt. HOLD≥1 guarantees it at least one cycle to do so before re-arbitration.
- din of non-winners is don't-care. din of the winner is sampled only on the capture edge.

## Timing
- Reset values: gnt=0, dout=0, dout_valid=0, owner=0, busy=0, state=IDLE, ptr=0, cnt=0.
- Reset dominates every other condition on the same edge, including mid-HOLD. Requests present on a reset edge are dropped.
- Capture latency: req is sampled high in IDLE on edge t. dout, owner, gnt and busy are visible after edge t, so there is 1 cycle from request to data.
- gnt is high for exactly one cycle, from edge t to edge t+1.
- busy is high for exactly HOLD cycles, edges t → t+HOLD.
- The earliest next capture is on edge t+HOLD+1. Sustained throughput is 1 capture per HOLD+1 cycles.
- Simultaneous requests: exactly one grant per capture. With all NREQ requesters continuously asserted, grants rotate 0,1,…,NREQ−1,0,…
- Pointer wrap: a win by NREQ−1 sets ptr to 0.
- A requester that holds req through the hold window and is the only requester is re-granted at t+HOLD+1. This is legal and gets a fresh capture.
- Reset released with req already high: the first capture occurs on the first edge where rst=1.

## Test plan
- Reset: hold rst=0 for 2 cycles with req=4'b1111. Required: gnt=0, dout=0, dout_valid=0, owner=0, busy=0 throughout.
- Single requester: req=4'b0100, din slice 2 = 4'b1010, HOLD=2. Required after the next edge: dout=1010, owner=2, gnt=0100 for 1 cycle, busy for 2 cycles. Then drop req and check there is no further grant.
- All requesting, constant req=4'b1111, distinct words 0001/0010/0100/1000 on slices 0..3. Required: owner sequence 0,1,2,3,0, captures spaced exactly HOLD+1=3 cycles apart, dout tracking the matching slice each time.
- Priority after wrap: after a grant to 3, assert req=4'b1001. Required: the next grant goes to 0, then the following one to 3.
- Reset mid-hold: capture from requester 1, then drive rst=0 on the cycle after the grant. Required: all outputs return to reset values on that edge. After release with req=4'b0010, the next capture is on the first rst=1 edge and busy restarts its full HOLD count.
- Requests during hold: assert req=4'b0001 while busy=1. Required: dout unchanged and gnt=0 until edge t+HOLD+1, then capture of requester 0.
